// File: rtl/qdiv_result_fifo.sv
// Captures divider results on the rising edge of i_complete, converts sign-magnitude to two's complement, queues DEPTH entries.
// One-cycle latency; a capture into a full FIFO without a same-cycle pop is lost and sets sticky o_drop. Optional macro: QDIV_RESULT_SAT_EN.
module qdiv_result_fifo #(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N-1:0]               i_quotient,
  input  logic                       i_complete,
  input  logic                       i_overflow,
  output logic                       o_space,
  output logic                       o_m_valid,
  input  logic                       i_m_ready,
  output logic [N-1:0]               o_m_data,
  output logic                       o_m_ovf,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (Q < 0 || Q >= N || DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("qdiv_result_fifo: illegal Q/N/DEPTH combination");
    end
  endgenerate

  logic            r_prev_complete;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_drop;
  logic [N:0]      r_mem [DEPTH];

  logic            w_capture;
  logic            w_pop;
  logic            w_full;
  logic            w_push;
  logic [N-1:0]    w_mag;
  logic [N-1:0]    w_conv;
  logic [N-1:0]    w_data;
  logic [N:0]      w_head;

  assign w_capture = i_complete & ~r_prev_complete;
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = o_m_valid & i_m_ready;
  // A full FIFO still takes a capture when the head leaves in the same cycle.
  assign w_push    = w_capture & (~w_full | w_pop);

  assign w_mag = {1'b0, i_quotient[N-2:0]};

  always_comb begin
    w_conv = w_mag;
    if (i_quotient[N-1]) begin
      w_conv = (w_mag == '0) ? '0 : ('0 - w_mag);
    end
  end

`ifdef QDIV_RESULT_SAT_EN
  always_comb begin
    w_data = w_conv;
    if (i_overflow) begin
      w_data = i_quotient[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end
`else
  assign w_data = w_conv;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev_complete <= 1'b1;
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_drop          <= 1'b0;
    end else begin
      r_prev_complete <= i_complete;
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (w_capture && w_full && !w_pop) begin
        r_drop <= 1'b1;
      end
    end
  end

  // Storage needs no reset: nothing is read out while the count is zero.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_data, i_overflow};
    end
  end

  assign w_head    = r_mem[r_rptr];
  assign o_m_valid = (r_count != '0);
  assign o_space   = ~w_full;
  assign o_m_data  = o_m_valid ? w_head[N:1] : '0;
  assign o_m_ovf   = o_m_valid & w_head[0];
  assign o_count   = r_count;
  assign o_drop    = r_drop;

endmodule

// File: tb/tb_qdiv_result_fifo.sv
// Scoreboard bench for qdiv_result_fifo (Q=15, N=32, DEPTH=4): a queue-based reference model fills on captures,
// a negedge monitor pops it on every handshake and checks status outputs each cycle.
module tb_qdiv_result_fifo;
  localparam int N = 32;
  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_quotient = '0;
  logic        i_complete = 1'b1;
  logic        i_overflow = 1'b0;
  logic        i_m_ready = 1'b0;
  logic        o_space;
  logic        o_m_valid;
  logic [31:0] o_m_data;
  logic        o_m_ovf;
  logic [2:0]  o_count;
  logic        o_drop;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] sb[$];
  logic        m_prev = 1'b1;
  logic        m_drop = 1'b0;

  qdiv_result_fifo #(.Q(15), .N(N), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_quotient(i_quotient), .i_complete(i_complete),
    .i_overflow(i_overflow), .o_space(o_space), .o_m_valid(o_m_valid), .i_m_ready(i_m_ready),
    .o_m_data(o_m_data), .o_m_ovf(o_m_ovf), .o_count(o_count), .o_drop(o_drop)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion in plain signed arithmetic.
  function automatic logic [32:0] model_conv(input logic [31:0] q, input logic o);
    longint mag;
    longint v;
    mag = longint'(q[30:0]);
    v = q[31] ? -mag : mag;
`ifdef QDIV_RESULT_SAT_EN
    if (o) v = q[31] ? -(64'sd1 <<< 31) : ((64'sd1 <<< 31) - 1);
`endif
    return {v[31:0], o};
  endfunction

  always @(negedge i_rst_n) begin
    sb.delete();
    m_prev = 1'b1;
    m_drop = 1'b0;
  end

  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      m_prev = 1'b1;
    end else begin
      if (i_complete && !m_prev) begin
        // The monitor has already removed this cycle's popped head, so free room here includes it.
        if (sb.size() < DEPTH) sb.push_back(model_conv(i_quotient, i_overflow));
        else m_drop = 1'b1;
      end
      m_prev = i_complete;
    end
  end

  always @(negedge i_clk) begin
    logic [32:0] e;
    chk("count", 64'(o_count), 64'(sb.size()));
    chk("valid", 64'(o_m_valid), 64'(sb.size() != 0));
    chk("space", 64'(o_space), 64'(sb.size() != DEPTH));
    chk("drop", 64'(o_drop), 64'(m_drop));
    if (i_rst_n && o_m_valid && i_m_ready) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("pop_data", 64'(o_m_data), 64'(e[32:1]));
        chk("pop_ovf", 64'(o_m_ovf), 64'(e[0]));
      end
    end
  end

  task automatic drive(input logic c, input logic [31:0] q, input logic o, input logic r);
    @(posedge i_clk);
    #1;
    i_complete = c;
    i_quotient = q;
    i_overflow = o;
    i_m_ready  = r;
  endtask

  task automatic pulse(input logic [31:0] q, input logic o, input logic r);
    drive(1'b0, q, o, r);
    drive(1'b1, q, o, r);
  endtask

  task automatic directed_one(input logic [31:0] q, input logic o, input logic [31:0] exp_d, input string name);
    pulse(q, o, 1'b0);
    drive(1'b1, q, o, 1'b0);
    @(negedge i_clk);
    chk({name, "_data"}, 64'(o_m_data), 64'(exp_d));
    chk({name, "_ovf"}, 64'(o_m_ovf), 64'(o));
    drive(1'b1, q, o, 1'b1);
    drive(1'b1, q, o, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #3;
    i_complete = 1'b1;
    i_rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(o_m_valid), 64'(0));
    chk("rst_count", 64'(o_count), 64'(0));
    chk("rst_space", 64'(o_space), 64'(1));
    chk("rst_drop", 64'(o_drop), 64'(0));
    chk("rst_data", 64'(o_m_data), 64'(0));
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] q;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("init_count", 64'(o_count), 64'(0));
    chk("init_space", 64'(o_space), 64'(1));
    #1;
    i_rst_n = 1'b1;

    directed_one(32'h0001_8000, 1'b0, 32'h0001_8000, "pos");
    directed_one(32'h8001_8000, 1'b0, 32'hFFFE_8000, "neg");
    directed_one(32'h8000_0000, 1'b0, 32'h0000_0000, "negzero");
`ifdef QDIV_RESULT_SAT_EN
    directed_one(32'h8000_1234, 1'b1, 32'h8000_0000, "ovf_sat");
`else
    directed_one(32'h8000_1234, 1'b1, 32'hFFFF_EDCC, "ovf_nosat");
`endif

    // Five captures with no consumer: the fifth is lost.
    for (int i = 0; i < 5; i++) pulse(32'h0000_1000 * (i + 1), 1'b0, 1'b0);
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    @(negedge i_clk);
    chk("full_count", 64'(o_count), 64'(4));
    chk("full_space", 64'(o_space), 64'(0));
    chk("full_drop", 64'(o_drop), 64'(1));
    chk("full_head", 64'(o_m_data), 64'(32'h0000_1000));
    repeat (6) drive(1'b1, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'h0, 1'b0, 1'b0);

    do_reset();

    // Full FIFO with capture and pop on the same edge.
    for (int i = 0; i < 4; i++) pulse(32'h8000_0100 + i, 1'b0, 1'b0);
    drive(1'b0, 32'h0000_7777, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_7777, 1'b0, 1'b1);
    drive(1'b1, 32'h0000_7777, 1'b0, 1'b0);
    @(negedge i_clk);
    chk("fullpop_count", 64'(o_count), 64'(4));
    chk("fullpop_drop", 64'(o_drop), 64'(0));
    repeat (6) drive(1'b1, 32'h0, 1'b0, 1'b1);

    // Reset with entries stored and complete held high.
    pulse(32'h0000_0011, 1'b0, 1'b0);
    pulse(32'h0000_0022, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0033, 1'b0, 1'b0);
    do_reset();
    repeat (4) drive(1'b1, 32'h0000_0044, 1'b0, 1'b1);
    @(negedge i_clk);
    chk("post_rst_nocapture", 64'(o_count), 64'(0));
    pulse(32'h0000_0055, 1'b1, 1'b0);
    drive(1'b1, 32'h0000_0055, 1'b0, 1'b0);
    @(negedge i_clk);
    chk("post_rst_capture", 64'(o_count), 64'(1));
    drive(1'b1, 32'h0, 1'b0, 1'b1);

    // Randomized traffic; zero magnitudes and overflow appear often.
    for (int i = 0; i < 3000; i++) begin
      q = $urandom();
      if ($urandom_range(0, 7) == 0) q[30:0] = '0;
      drive($urandom_range(0, 2) != 0, q, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end
    repeat (8) drive(1'b1, 32'h0, 1'b0, 1'b1);
    @(negedge i_clk);
    chk("final_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
